spi_flash_emu_ctrl: RTL and testbench
=====================================

Name: spi_flash_emu_ctrl

Overview:
- Sequences the flash-image memory port and the SO output shift register so the FPGA can answer SPI flash READ (0x03) transactions, using the sniffer's address-tracking outputs (addr_hi, addr_lo, addr_changed, load, shift).
- Holds a current word and one prefetched word, fetches 32-bit words over a req/ack memory port, and serves bytes MSB-first on spi_so.
- Sits between spi_sniffer and the shared SRAM arbiter.

Parameters:
PREFETCH, 1, 1 = fetch word addr_hi+1 after each demand fill; 0 = demand fetch only
FILL_BYTE, 8'hFF, byte driven when the requested word is not resident at load time

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
addr_hi  in  22  word address from sniffer
addr_lo  in  2  byte-in-word from sniffer
addr_changed  in  1  one-cycle pulse: addr_hi changed
load  in  1  one-cycle pulse: load the next byte into the shift register
shift  in  1  one-cycle pulse: advance the shift register one bit
mem_req  out  1  memory request, held until mem_ack
mem_addr  out  22  word address, stable while mem_req=1
mem_ack  in  1  one-cycle pulse; mem_rdata valid in that cycle
mem_rdata  in  32  read word, big-endian (byte 0 = [31:24])
spi_so  out  1  serial data out = sr[7]
underrun  out  1  one-cycle pulse: load with word not resident
hit_cnt  out  16  saturating count of loads served from a resident word
miss_cnt  out  16  saturating count of demand fetches started

Behaviour:
- Reset (reset=0, async) clears everything: mem_req=0, mem_addr=0, sr=8'hFF (spi_so=1), underrun=0, hit_cnt=0, miss_cnt=0, cur_valid=0, nxt_valid=0, state=IDLE.
- Buffers:
  - cur = {cur_tag[21:0], cur_data[31:0], cur_valid}
  - nxt = {nxt_tag, nxt_data, nxt_valid}
  - Resident means cur_valid && cur_tag==addr_hi.
- State machine IDLE / DEMAND / PREFETCH:
  - IDLE, on addr_changed (or each cycle while addr_hi is not resident):
    - nxt_valid && nxt_tag==addr_hi: promote nxt into cur this cycle, clear nxt_valid. If PREFETCH, go to PREFETCH with mem_addr=addr_hi+1.
    - Otherwise: go to DEMAND with mem_addr=addr_hi, mem_req=1, miss_cnt+1.
    - Resident: stay in IDLE.
  - DEMAND, on mem_ack:
    - cur <= {mem_addr, mem_rdata, 1}, mem_req=0.
    - If PREFETCH and mem_addr==addr_hi: go to PREFETCH (mem_addr+1, req=1). Else go to IDLE.
  - PREFETCH, on mem_ack: nxt <= {mem_addr, mem_rdata, 1}, mem_req=0, go to IDLE.
- Request rules:
  - mem_req rises one cycle after the decision and stays high until ack.
  - mem_addr never changes while mem_req=1.
  - An in-flight request is never abandoned. If addr_hi changes mid-fetch, the fetch completes and is stored, and IDLE then re-evaluates.
  - Address arithmetic is 22-bit; prefetch address 22'h3FFFFF+1 wraps to 0.
- Shift register:
  - On load, if resident: sr <= byte addr_lo of cur_data (0→[31:24] … 3→[7:0]), hit_cnt+1.
  - On load, if not resident: sr <= FILL_BYTE, underrun=1 for one cycle.
  - On shift: sr <= {sr[6:0],1}.
  - load and shift in the same cycle: load wins.
  - Promotion, fill and load in the same cycle: residency is evaluated on the pre-update buffers. The fill does not serve that load.
- Latency: a demand fill is visible to a load from the cycle after mem_ack.
- Counters saturate at 16'hFFFF.
- mem_ack with mem_req=0 is ignored.

Test Plan:
- Reset then addr_hi=22'h000010 with addr_changed pulse, ack after 3 cycles with rdata=32'hA1B2C3D4 → mem_req held 3 cycles at mem_addr 0x10; miss_cnt=1; with PREFETCH, mem_req reasserts at 0x11.
- After the fill, load with addr_lo=2, then 7 shift pulses → spi_so sequence is 1,1,0,0,0,0,1,1 (0xC3); hit_cnt=1.
- Sequential read: addr_hi 0x10→0x11 after prefetch ack (rdata 32'h55667788), load addr_lo=0 → no demand fetch; miss_cnt unchanged; sr=0x55; new prefetch issued at 0x12.
- Load with no resident word (no ack yet) → underrun pulses once; sr=8'hFF; spi_so=1.
- Wrap: demand at 22'h3FFFFF → prefetch mem_addr=22'h000000.
- Async reset asserted mid-DEMAND with mem_req=1 → mem_req drops immediately, buffers invalid; ack arriving after reset release is ignored.

Source files
------------

// File: rtl/spi_flash_emu_ctrl.sv
// SPI flash READ emulation controller: keeps a current and a prefetched
// 32-bit flash word, fetches over a req/ack memory port, and serves the
// addressed byte MSB-first on spi_so.
module spi_flash_emu_ctrl #(
   parameter bit         PREFETCH  = 1'b1,
   parameter logic [7:0] FILL_BYTE = 8'hFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [21:0] addr_hi,
   input  logic [1:0]  addr_lo,
   input  logic        addr_changed,
   input  logic        load,
   input  logic        shift,
   output logic        mem_req,
   output logic [21:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        spi_so,
   output logic        underrun,
   output logic [15:0] hit_cnt,
   output logic [15:0] miss_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_DEMAND, S_PREFETCH} state_t;

   state_t      state_q, state_d;
   logic        req_d;
   logic [21:0] addr_d;

   logic [21:0] cur_tag, nxt_tag;
   logic [31:0] cur_data, nxt_data;
   logic        cur_valid, nxt_valid;
   logic [7:0]  sr;
   logic [7:0]  sel_byte;

   logic resident, nxt_hit, evaluate, ack_ok;
   logic promote, fill_cur, fill_nxt, miss_inc;

   assign resident = cur_valid && (cur_tag == addr_hi);
   assign nxt_hit  = nxt_valid && (nxt_tag == addr_hi);
   // A fresh address and a still-missing address both trigger a look-up.
   assign evaluate = addr_changed || !resident;
   // An ack without an outstanding request is a stray and is dropped.
   assign ack_ok   = mem_req && mem_ack;
   assign spi_so   = sr[7];

   // Next-state, request and buffer-update decisions.
   always_comb begin
      // NOTE: every signal gets a default first, so no path can infer a latch.
      state_d  = state_q;
      req_d    = mem_req;
      addr_d   = mem_addr;
      promote  = 1'b0;
      fill_cur = 1'b0;
      fill_nxt = 1'b0;
      miss_inc = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (evaluate && !resident) begin
               if (nxt_hit) begin
                  promote = 1'b1;
                  if (PREFETCH) begin
                     state_d = S_PREFETCH;
                     req_d   = 1'b1;
                     addr_d  = addr_hi + 22'd1;
                  end
               end else begin
                  state_d  = S_DEMAND;
                  req_d    = 1'b1;
                  addr_d   = addr_hi;
                  miss_inc = 1'b1;
               end
            end
         end
         S_DEMAND: begin
            // The fetch always completes; a moved address is re-checked in IDLE.
            if (ack_ok) begin
               fill_cur = 1'b1;
               req_d    = 1'b0;
               state_d  = S_IDLE;
               if (PREFETCH && (mem_addr == addr_hi)) begin
                  state_d = S_PREFETCH;
                  req_d   = 1'b1;
                  addr_d  = mem_addr + 22'd1;
               end
            end
         end
         S_PREFETCH: begin
            if (ack_ok) begin
               fill_nxt = 1'b1;
               req_d    = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register and memory-port request registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q  <= state_d;
         mem_req  <= req_d;
         mem_addr <= addr_d;
      end
   end

   // Current / prefetch word buffers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: data is cleared too, not just the valid bits, so tags never compare against X.
         cur_tag   <= '0;
         cur_data  <= '0;
         cur_valid <= 1'b0;
         nxt_tag   <= '0;
         nxt_data  <= '0;
         nxt_valid <= 1'b0;
      end else begin
         if (promote) begin
            cur_tag   <= nxt_tag;
            cur_data  <= nxt_data;
            cur_valid <= 1'b1;
            nxt_valid <= 1'b0;
         end
         if (fill_cur) begin
            cur_tag   <= mem_addr;
            cur_data  <= mem_rdata;
            cur_valid <= 1'b1;
         end
         if (fill_nxt) begin
            nxt_tag   <= mem_addr;
            nxt_data  <= mem_rdata;
            nxt_valid <= 1'b1;
         end
      end
   end

   // Big-endian byte select out of the current word.
   always_comb begin
      unique case (addr_lo)
         2'd0:    sel_byte = cur_data[31:24];
         2'd1:    sel_byte = cur_data[23:16];
         2'd2:    sel_byte = cur_data[15:8];
         default: sel_byte = cur_data[7:0];
      endcase
   end

   // Output shift register, underrun pulse and saturating statistics.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr       <= 8'hFF;
         underrun <= 1'b0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         underrun <= 1'b0;
         // Residency uses the buffers as they were before this edge's fill.
         if (load) begin
            if (resident) begin
               sr <= sel_byte;
               if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end else begin
               sr       <= FILL_BYTE;
               underrun <= 1'b1;
            end
         end else if (shift) begin
            sr <= {sr[6:0], 1'b1};
         end
         if (miss_inc && (miss_cnt != 16'hFFFF)) miss_cnt <= miss_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_spi_flash_emu_ctrl.sv
// Randomized scoreboard bench for spi_flash_emu_ctrl: a word-level cache
// model predicts memory requests and served bytes; monitors compare them
// as the DUT presents memory handshakes and serial bytes.
module tb_spi_flash_emu_ctrl;

   localparam bit         PREFETCH  = 1'b1;
   localparam logic [7:0] FILL_BYTE = 8'hFF;

   logic        clk = 1'b0;
   logic        reset;
   logic [21:0] addr_hi;
   logic [1:0]  addr_lo;
   logic        addr_changed, load, shift;
   logic        mem_req;
   logic [21:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        spi_so, underrun;
   logic [15:0] hit_cnt, miss_cnt;

   logic        resp_ack, man_ack, resp_en;
   logic [31:0] resp_data, man_data;

   assign mem_ack   = resp_ack | man_ack;
   assign mem_rdata = man_ack ? man_data : resp_data;

   spi_flash_emu_ctrl #(.PREFETCH(PREFETCH), .FILL_BYTE(FILL_BYTE)) dut (
      .clk(clk), .reset(reset), .addr_hi(addr_hi), .addr_lo(addr_lo),
      .addr_changed(addr_changed), .load(load), .shift(shift),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .spi_so(spi_so), .underrun(underrun),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] b; logic ur; } exp_byte_t;

   int          checks = 0;
   int          failures = 0;
   int          acks_seen = 0;
   int          acks_expected = 0;
   logic [21:0] req_q[$];
   exp_byte_t   byte_q[$];

   // Reference model: which words the controller holds, as plain tags.
   logic [21:0] m_cur, m_nxt;
   bit          m_cur_v = 1'b0, m_nxt_v = 1'b0;
   int          m_hits = 0, m_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [31:0] mem_word(input logic [21:0] a);
      if (a == 22'h000010) return 32'hA1B2C3D4;
      if (a == 22'h000011) return 32'h55667788;
      return ({10'd0, a} * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] lo);
      logic [31:0] s;
      s = w >> (8 * (3 - int'(lo)));
      return s[7:0];
   endfunction

   function automatic void expect_req(input logic [21:0] a);
      req_q.push_back(a);
      acks_expected++;
   endfunction

   // What a look-up of word a does to the two buffers and the memory port.
   function automatic void predict(input logic [21:0] a);
      logic [21:0] nx;
      nx = a + 22'd1;
      if (m_cur_v && m_cur == a) return;
      if (!(m_nxt_v && m_nxt == a)) begin
         expect_req(a);
         m_miss++;
      end else begin
         m_nxt_v = 1'b0;
      end
      m_cur = a;
      m_cur_v = 1'b1;
      if (PREFETCH) begin
         expect_req(nx);
         m_nxt = nx;
         m_nxt_v = 1'b1;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_acks();
      for (int i = 0; i < 200 && acks_seen < acks_expected; i++) tick();
      if (acks_seen < acks_expected) fail_now("ack_timeout");
   endtask

   task automatic serve(input logic [1:0] lo, input logic [7:0] exp_b, input logic exp_ur);
      exp_byte_t e;
      e.b = exp_b;
      e.ur = exp_ur;
      byte_q.push_back(e);
      addr_lo = lo;
      load = 1'b1;
      shift = 1'($urandom_range(0, 1));
      tick();
      load = 1'b0;
      shift = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if ($urandom_range(0, 2) == 0) tick();
         shift = 1'b1;
         tick();
         shift = 1'b0;
      end
      tick();
   endtask

   task automatic check_counts();
      check("hit_cnt", {16'd0, hit_cnt}, m_hits);
      check("miss_cnt", {16'd0, miss_cnt}, m_miss);
   endtask

   task automatic access(input logic [21:0] a, input logic [1:0] lo);
      predict(a);
      addr_hi = a;
      addr_changed = 1'b1;
      tick();
      addr_changed = 1'b0;
      wait_acks();
      serve(lo, byte_of(mem_word(a), lo), 1'b0);
      m_hits++;
      check_counts();
   endtask

   task automatic underrun_access(input logic [21:0] a);
      predict(a);
      addr_hi = a;
      addr_changed = 1'b1;
      tick();
      addr_changed = 1'b0;
      serve(2'($urandom_range(0, 3)), FILL_BYTE, 1'b1);
      wait_acks();
      check_counts();
   endtask

   function automatic logic [21:0] pick_absent();
      logic [21:0] a;
      do a = 22'($urandom); while ((m_cur_v && a == m_cur) || (m_nxt_v && a == m_nxt));
      return a;
   endfunction

   // Memory responder: acks each request after a random 0..3 cycle wait.
   initial begin
      int delay;
      delay = 3;
      resp_ack = 1'b0;
      resp_data = '0;
      forever begin
         tick();
         resp_ack = 1'b0;
         if (resp_en && reset && mem_req) begin
            if (delay == 0) begin
               resp_ack = 1'b1;
               resp_data = mem_word(mem_addr);
               delay = $urandom_range(0, 3);
            end else begin
               delay--;
            end
         end
      end
   end

   // Request monitor: each completed handshake must match the next predicted address.
   initial begin
      bit          busy;
      logic [21:0] held;
      busy = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            busy = 1'b0;
         end else if (mem_req) begin
            if (!busy) begin
               busy = 1'b1;
               held = mem_addr;
            end
            if (mem_ack) begin
               check("mem_addr_stable", {10'd0, mem_addr}, {10'd0, held});
               if (req_q.size() == 0) fail_now("unexpected_request");
               else check("mem_addr", {10'd0, mem_addr}, {10'd0, req_q.pop_front()});
               acks_seen++;
               busy = 1'b0;
            end
         end
      end
   end

   // Serial monitor: rebuilds each byte from spi_so after a load and seven shifts.
   initial begin
      bit        prev_load, prev_shift, active, got_ur;
      int        nbits;
      logic [7:0] bits;
      exp_byte_t e;
      prev_load = 1'b0;
      prev_shift = 1'b0;
      active = 1'b0;
      got_ur = 1'b0;
      nbits = 0;
      bits = '0;
      forever begin
         @(negedge clk);
         if (prev_load) begin
            got_ur = underrun;
            bits = {7'd0, spi_so};
            nbits = 1;
            active = 1'b1;
         end else if (prev_shift && active) begin
            bits = {bits[6:0], spi_so};
            nbits++;
         end
         if (active && nbits == 8) begin
            active = 1'b0;
            if (byte_q.size() == 0) begin
               fail_now("unexpected_byte");
            end else begin
               e = byte_q.pop_front();
               check("spi_byte", {24'd0, bits}, {24'd0, e.b});
               check("underrun", {31'd0, got_ur}, {31'd0, e.ur});
            end
         end
         prev_load = load;
         prev_shift = shift;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic [21:0] a;
      int          kind;
      reset = 1'b0;
      addr_hi = '0;
      addr_lo = '0;
      addr_changed = 1'b0;
      load = 1'b0;
      shift = 1'b0;
      man_ack = 1'b0;
      man_data = '0;
      resp_en = 1'b1;
      repeat (3) tick();

      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_addr", {10'd0, mem_addr}, 32'd0);
      check("rst_spi_so", {31'd0, spi_so}, 32'd1);
      check("rst_underrun", {31'd0, underrun}, 32'd0);
      check_counts();

      // Out of reset word 0 is not resident, so it is fetched at once.
      predict(22'd0);
      reset = 1'b1;
      wait_acks();
      check_counts();

      access(22'h000010, 2'd2);       // demand 0x10, prefetch 0x11, byte 0xC3
      access(22'h000011, 2'd0);       // promoted, byte 0x55, prefetch 0x12
      access(22'h000011, 2'd3);       // already resident
      underrun_access(22'h000200);
      access(22'h3FFFFF, 2'd1);       // prefetch wraps to word 0
      access(22'h000000, 2'd2);       // promoted from the wrapped prefetch

      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 4);
         case (kind)
            0: access(m_cur + 22'd1, 2'($urandom_range(0, 3)));
            1: access(m_cur, 2'($urandom_range(0, 3)));
            2: access(22'($urandom), 2'($urandom_range(0, 3)));
            3: access(22'h3FFFFF, 2'($urandom_range(0, 3)));
            default: underrun_access(pick_absent());
         endcase
      end

      // Asynchronous reset in the middle of a demand fetch.
      resp_en = 1'b0;
      repeat (4) tick();
      a = pick_absent();
      addr_hi = a;
      addr_changed = 1'b1;
      tick();
      addr_changed = 1'b0;
      tick();
      tick();
      check("mid_demand_req", {31'd0, mem_req}, 32'd1);
      check("mid_demand_addr", {10'd0, mem_addr}, {10'd0, a});
      #2;
      reset = 1'b0;
      #1;
      check("async_req_drop", {31'd0, mem_req}, 32'd0);
      check("async_miss_clr", {16'd0, miss_cnt}, 32'd0);
      tick();
      reset = 1'b1;
      man_ack = 1'b1;
      man_data = 32'h0BADF00D;
      tick();
      man_ack = 1'b0;
      check("post_rst_req", {31'd0, mem_req}, 32'd1);
      check("post_rst_addr", {10'd0, mem_addr}, {10'd0, a});
      check("post_rst_miss", {16'd0, miss_cnt}, 32'd1);
      serve(2'd0, FILL_BYTE, 1'b1);
      check("post_rst_hit", {16'd0, hit_cnt}, 32'd0);

      repeat (4) tick();
      check("byte_q_drained", byte_q.size(), 32'd0);
      check("req_q_drained", req_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
